enc_joint_sched: RTL and testbench
==================================

Name: enc_joint_sched

Overview:
Per-joint position scheduler for the arm. Takes divided cw/ccw step pulses from N_JOINTS encoder dividers and accumulates a signed pending delta per joint. Keeps each joint's clamped absolute position. Round-robin serialises updates onto one shared valid/ready command channel feeding the servo/PWM command stage.

Parameters:
N_JOINTS, 4, number of joints (2..8)
POS_W, 12, unsigned position width
DELTA_W, 4, signed pending-delta accumulator width
POS_MIN, 0, lower position clamp
POS_MAX, 4095, upper position clamp (POS_MIN < POS_MAX <= 2^POS_W-1)
POS_RESET, 2048, position loaded at reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cw_in  in  N_JOINTS  1-cycle cw step pulse per joint
ccw_in  in  N_JOINTS  1-cycle ccw step pulse per joint
cmd_valid  out  1  command available
cmd_ready  in  1  consumer accepts command when high with cmd_valid
cmd_joint  out  $clog2(N_JOINTS)  joint index of command
cmd_pos  out  POS_W  new clamped absolute position
cmd_delta  out  DELTA_W  signed delta applied (pre-clamp)
cmd_sat  out  1  high if clamp altered the result
busy  out  1  high when state is ISSUE or any pending delta is nonzero

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all pending = 0; all positions = POS_RESET; RR pointer = 0; state IDLE; cmd_valid = 0; cmd_joint/cmd_pos/cmd_delta/cmd_sat = 0; busy = 0.
- Reset mid-ISSUE: command dropped, no handshake required.
- Accumulate, every cycle, per joint j:
  - cw_in[j] only -> pend[j] += 1
  - ccw_in[j] only -> pend[j] -= 1
  - both or neither -> no change
  - Saturate at +(2^(DELTA_W-1)-1) and -(2^(DELTA_W-1)-1); 4-bit default range is +/-7, and -8 is never produced.
- FSM, two states:
  - IDLE: if any pend != 0, grant the first nonzero joint searching from RR pointer upward with wrap. At the clock edge:
    - latch cmd_joint and cmd_delta = pend[g]
    - compute pos[g] + pend[g] at POS_W+2 signed width, clamp to [POS_MIN, POS_MAX]
    - write the result to pos[g] and cmd_pos; cmd_sat = (clamped != unclamped)
    - clear pend[g]; RR pointer = g+1 mod N_JOINTS
    - cmd_valid <= 1; go to ISSUE.
  - ISSUE: hold all cmd_* outputs stable while cmd_ready = 0. When cmd_valid & cmd_ready: cmd_valid <= 0; go to IDLE.
- Grant spacing: minimum one IDLE cycle between grants, so peak throughput is one command per 2 cycles.
- Latency: pulse in cycle k with the machine idle -> cmd_valid high in cycle k+2.
- Position commit: the position is committed at grant, not at handshake.
- Pulse on granted joint in the grant cycle: applied to the cleared accumulator, so pend[g] = +/-1 after the edge. Never lost.
- Pulses during ISSUE: accumulate normally, including on cmd_joint.
- Joint already at a clamp limit: a request pushing further still produces a command with cmd_pos unchanged and cmd_sat = 1.

Optional Feature:
Macro ENC_JOINT_SCHED_HOME_EN.
- Defined:
  - Adds input home_in [N_JOINTS], the active-high limit switch per joint.
  - While home_in[j] is high: pos[j] forced to POS_MIN; pend[j] held at 0; ccw pulses ignored; cw pulses ignored.
  - A grant never selects a homed joint.
  - If home_in[j] rises during ISSUE for j, the in-flight command completes unchanged.
- Undefined: port absent; positions only change via grants.

Decomposition:
- Package enc_pkg:
  - localparam JOINT_W = $clog2(N_JOINTS) default
  - typedef enum logic {IDLE, ISSUE} sched_state_e
  - function sat_add_delta (saturating accumulate)
  - function clamp_pos
- One sub-module, enc_rr_pick: combinational round-robin priority picker. Inputs are the request vector and pointer; outputs are the grant index and any_req.

Test Plan:
- Reset, then cw_in[1] pulse in cycle 0, cmd_ready = 1 -> cycle 2: cmd_valid = 1, cmd_joint = 1, cmd_delta = +1, cmd_pos = 2049, cmd_sat = 0; busy drops after the handshake.
- 10 cw pulses on joint 0 while cmd_ready = 0 and ISSUE is blocked on joint 2 -> pend[0] saturates at +7; after release, next command is joint 0 with cmd_delta = 7, cmd_pos = 2055.
- cw_in and ccw_in both high on joint 3 for 5 cycles -> no command, busy = 0.
- Joints 0, 1, 2, 3 all pending simultaneously, cmd_ready = 1 -> grant order 0, 1, 2, 3; repeat with pointer at 2 -> order 2, 3, 0, 1; commands spaced 2 cycles.
- Joint 0 at 4090, 7 cw pulses -> cmd_pos = 4095, cmd_sat = 1; further cw pulse -> cmd_pos = 4095, cmd_sat = 1.
- cmd_valid held with cmd_ready = 0 for 4 cycles, reset asserted in cycle 2 -> next cycle cmd_valid = 0, all positions 2048. With HOME_EN, home_in[1] high -> pos[1] = 0, cw/ccw on joint 1 produce no command.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and arithmetic helpers for the joint position scheduler.
package enc_pkg;

  localparam int N_JOINTS_DEF = 4;
  localparam int JOINT_W = $clog2(N_JOINTS_DEF);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} sched_state_e;

  // Symmetric saturation: the most negative code is never produced.
  function automatic int sat_add_delta(input int acc, input int step, input int lim);
    int s;
    s = acc + step;
    if (s > lim) s = lim;
    else if (s < -lim) s = -lim;
    return s;
  endfunction

  function automatic int clamp_pos(input int val, input int lo, input int hi);
    int c;
    c = val;
    if (c < lo) c = lo;
    else if (c > hi) c = hi;
    return c;
  endfunction

endpackage

// File: rtl/enc_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module enc_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any_req
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx[W-1:0]]) begin
        found = 1'b1;
        grant = idx[W-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/enc_joint_sched.sv
// Per-joint step accumulator and clamped position keeper, serialised round-robin onto one command channel.
// Optional limit-switch homing inputs are enabled by defining ENC_JOINT_SCHED_HOME_EN.
module enc_joint_sched
  import enc_pkg::*;
#(
  parameter int N_JOINTS  = 4,
  parameter int POS_W     = 12,
  parameter int DELTA_W   = 4,
  parameter int POS_MIN   = 0,
  parameter int POS_MAX   = 4095,
  parameter int POS_RESET = 2048,
  localparam int JW       = $clog2(N_JOINTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_JOINTS-1:0] cw_in,
  input  logic [N_JOINTS-1:0] ccw_in,
`ifdef ENC_JOINT_SCHED_HOME_EN
  input  logic [N_JOINTS-1:0] home_in,
`endif
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [JW-1:0]       cmd_joint,
  output logic [POS_W-1:0]    cmd_pos,
  output logic [DELTA_W-1:0]  cmd_delta,
  output logic                cmd_sat,
  output logic                busy
);

  localparam int PEND_LIM = 2 ** (DELTA_W - 1) - 1;

  sched_state_e               state;
  logic [JW-1:0]              rr_ptr;
  logic signed [DELTA_W-1:0]  pend     [N_JOINTS];
  logic signed [DELTA_W-1:0]  pend_nxt [N_JOINTS];
  logic [POS_W-1:0]           pos      [N_JOINTS];

  logic [N_JOINTS-1:0] home;
  logic [N_JOINTS-1:0] nz;
  logic [N_JOINTS-1:0] req;
  logic [JW-1:0]       grant;
  logic                any_req;
  logic                grant_fire;

`ifdef ENC_JOINT_SCHED_HOME_EN
  assign home = home_in;
`else
  assign home = '0;
`endif

  always_comb begin
    for (int j = 0; j < N_JOINTS; j++) begin
      nz[j]  = (pend[j] != '0);
      req[j] = nz[j] & ~home[j];
    end
  end

  enc_rr_pick #(.N(N_JOINTS), .W(JW)) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  assign grant_fire = (state == IDLE) && any_req;
  assign busy       = (state == ISSUE) || (|nz);

  // A pulse landing on the granted joint is applied to the freshly cleared accumulator.
  int step;
  int base;
  always_comb begin
    step = 0;
    base = 0;
    for (int j = 0; j < N_JOINTS; j++) begin
      step = (cw_in[j] && !ccw_in[j]) ? 1 : ((ccw_in[j] && !cw_in[j]) ? -1 : 0);
      base = (grant_fire && int'(grant) == j) ? 0 : int'(pend[j]);
      pend_nxt[j] = DELTA_W'(sat_add_delta(base, step, PEND_LIM));
      if (home[j]) pend_nxt[j] = '0;
    end
  end

  logic [POS_W-1:0]          pos_g;
  logic signed [DELTA_W-1:0] pend_g;
  logic signed [POS_W+1:0]   sum_w;
  int                        clamped;

  assign pos_g  = pos[grant];
  assign pend_g = pend[grant];
  assign sum_w  = $signed({2'b00, pos_g})
                + $signed({{(POS_W + 2 - DELTA_W){pend_g[DELTA_W-1]}}, pend_g});

  always_comb begin
    clamped = clamp_pos(int'(sum_w), POS_MIN, POS_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < N_JOINTS; j++) begin
        pend[j] <= '0;
        pos[j]  <= POS_W'(POS_RESET);
      end
      rr_ptr    <= '0;
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_joint <= '0;
      cmd_pos   <= '0;
      cmd_delta <= '0;
      cmd_sat   <= 1'b0;
    end else begin
      for (int j = 0; j < N_JOINTS; j++) begin
        pend[j] <= pend_nxt[j];
        if (home[j]) pos[j] <= POS_W'(POS_MIN);
      end
      case (state)
        IDLE: begin
          // Position is committed here, independent of when the consumer accepts.
          if (any_req) begin
            cmd_joint  <= grant;
            cmd_delta  <= pend_g;
            cmd_pos    <= POS_W'(clamped);
            cmd_sat    <= (clamped != int'(sum_w));
            pos[grant] <= POS_W'(clamped);
            rr_ptr     <= (int'(grant) == N_JOINTS - 1) ? '0 : grant + 1'b1;
            cmd_valid  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_joint_sched.sv
// Scoreboard bench for enc_joint_sched: directed stimulus pushes expected commands, a monitor checks each handshake.
module tb_enc_joint_sched;

  typedef struct packed {
    logic [1:0]  joint;
    logic [11:0] pos;
    logic [3:0]  delta;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cw_in, ccw_in;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_joint;
  logic [11:0] cmd_pos;
  logic [3:0]  cmd_delta;
  logic        cmd_sat, busy;
`ifdef ENC_JOINT_SCHED_HOME_EN
  logic [3:0]  home_in;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mpos [4];
  exp_t exp_q [$];
  int   hs_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  enc_joint_sched dut (
    .clk       (clk),
    .reset     (reset),
    .cw_in     (cw_in),
    .ccw_in    (ccw_in),
`ifdef ENC_JOINT_SCHED_HOME_EN
    .home_in   (home_in),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_joint (cmd_joint),
    .cmd_pos   (cmd_pos),
    .cmd_delta (cmd_delta),
    .cmd_sat   (cmd_sat),
    .busy      (busy)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(int j, int p, int d, bit s);
    exp_t e;
    e.joint = 2'(j);
    e.pos   = 12'(p);
    e.delta = 4'(d);
    e.sat   = s;
    return e;
  endfunction

  // Reference: apply delta, clamp to [0,4095], flag saturation.
  task automatic expect_step(int j, int d);
    int raw, c;
    raw = mpos[j] + d;
    c = (raw < 0) ? 0 : ((raw > 4095) ? 4095 : raw);
    exp_q.push_back(mk(j, c, d, c != raw));
    mpos[j] = c;
  endtask

  // Monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      exp_t e;
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got joint %0d pos %0d expected none", cmd_joint, cmd_pos);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_joint", cmd_joint, e.joint);
        chk("cmd_pos",   cmd_pos,   e.pos);
        chk("cmd_delta", cmd_delta, e.delta);
        chk("cmd_sat",   cmd_sat,   e.sat);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset  = 1'b1;
    cw_in  = '0;
    ccw_in = '0;
    tick;
    tick;
    reset = 1'b0;
    exp_q.delete();
    for (int j = 0; j < 4; j++) mpos[j] = 2048;
  endtask

  task automatic wait_valid(int max);
    int k = 0;
    while (!cmd_valid && k < max) begin
      tick;
      k++;
    end
    if (!cmd_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got no cmd_valid expected within %0d cycles", max);
    end
  endtask

  task automatic wait_idle(int max);
    int k = 0;
    while ((busy || cmd_valid || exp_q.size() != 0) && k < max) begin
      tick;
      k++;
    end
    if (busy || cmd_valid || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got %0d outstanding expected 0 within %0d cycles", exp_q.size(), max);
    end
  endtask

  // Stall the channel on blk, stack n cw pulses on tgt, then release.
  task automatic run_block(int blk, int tgt, int n);
    cmd_ready = 1'b0;
    expect_step(blk, 1);
    cw_in = 4'(1 << blk);
    tick;
    cw_in = '0;
    wait_valid(10);
    chk("blk_busy", busy, 1);
    expect_step(tgt, (n > 7) ? 7 : n);
    repeat (n) begin
      cw_in = 4'(1 << tgt);
      tick;
    end
    cw_in = '0;
    cmd_ready = 1'b1;
    wait_idle(60);
  endtask

  task automatic chk_spacing(string name);
    chk({name, "_count"}, hs_q.size(), 4);
    for (int i = 1; i < hs_q.size(); i++) chk(name, hs_q[i] - hs_q[i-1], 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cw_in     = '0;
    ccw_in    = '0;
    cmd_ready = 1'b1;
`ifdef ENC_JOINT_SCHED_HOME_EN
    home_in   = '0;
`endif
    do_reset;

    // Reset state
    chk("rst_valid", cmd_valid, 0);
    chk("rst_joint", cmd_joint, 0);
    chk("rst_pos",   cmd_pos,   0);
    chk("rst_delta", cmd_delta, 0);
    chk("rst_sat",   cmd_sat,   0);
    chk("rst_busy",  busy,      0);

    // Single cw pulse on joint 1: valid two cycles later
    exp_q.push_back(mk(1, 2049, 1, 0));
    mpos[1] = 2049;
    cw_in = 4'b0010;
    tick;
    cw_in = '0;
    chk("lat_c1_valid", cmd_valid, 0);
    chk("lat_c1_busy",  busy,      1);
    tick;
    chk("lat_c2_valid", cmd_valid, 1);
    tick;
    chk("lat_c3_valid", cmd_valid, 0);
    chk("lat_c3_busy",  busy,      0);

    // Joint 0 accumulator saturates at +7 behind a stalled joint-2 command
    run_block(2, 0, 10);

    // Simultaneous cw and ccw cancel
    cw_in  = 4'b1000;
    ccw_in = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("cancel_valid", cmd_valid, 0);
      chk("cancel_busy",  busy,      0);
    end
    cw_in  = '0;
    ccw_in = '0;
    tick;
    chk("cancel_valid_end", cmd_valid, 0);

    // Round-robin order from pointer 0, then from pointer 2
    do_reset;
    cmd_ready = 1'b1;
    hs_q.delete();
    for (int j = 0; j < 4; j++) expect_step(j, 1);
    cw_in = 4'b1111;
    tick;
    cw_in = '0;
    wait_idle(40);
    chk_spacing("rr0_spacing");
    expect_step(1, 1);
    cw_in = 4'b0010;
    tick;
    cw_in = '0;
    wait_idle(20);
    hs_q.delete();
    exp_q.push_back(mk(2, 2048, -1, 0));
    exp_q.push_back(mk(3, 2048, -1, 0));
    exp_q.push_back(mk(0, 2048, -1, 0));
    exp_q.push_back(mk(1, 2049, -1, 0));
    ccw_in = 4'b1111;
    tick;
    ccw_in = '0;
    wait_idle(40);
    chk_spacing("rr2_spacing");

    // Drive joint 0 to 4090, then into the upper clamp
    do_reset;
    for (int i = 0; i < 291; i++) run_block(1, 0, 7);
    run_block(1, 0, 5);
    chk("clamp_pre_pos_model", mpos[0] + errors * 0, 4090);
    run_block(1, 0, 7);
    cmd_ready = 1'b1;
    exp_q.push_back(mk(0, 4095, 1, 1));
    cw_in = 4'b0001;
    tick;
    cw_in = '0;
    wait_idle(20);

    // Reset while a command is stalled drops it and restores positions
    cmd_ready = 1'b0;
    cw_in = 4'b0100;
    tick;
    cw_in = '0;
    wait_valid(10);
    chk("hold0_joint", cmd_joint, 2);
    chk("hold0_pos",   cmd_pos,   2049);
    tick;
    chk("hold1_valid", cmd_valid, 1);
    chk("hold1_pos",   cmd_pos,   2049);
    tick;
    chk("hold2_valid", cmd_valid, 1);
    reset = 1'b1;
    tick;
    chk("rst_mid_valid", cmd_valid, 0);
    chk("rst_mid_busy",  busy,      0);
    chk("rst_mid_pos",   cmd_pos,   0);
    reset = 1'b0;
    exp_q.delete();
    for (int j = 0; j < 4; j++) mpos[j] = 2048;
    cmd_ready = 1'b1;
    expect_step(0, 1);
    expect_step(2, 1);
    cw_in = 4'b0101;
    tick;
    cw_in = '0;
    wait_idle(20);

`ifdef ENC_JOINT_SCHED_HOME_EN
    // Homed joint is pinned to the lower limit and never granted
    do_reset;
    home_in = 4'b0010;
    tick;
    for (int i = 0; i < 4; i++) begin
      cw_in  = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      ccw_in = (i % 2 == 0) ? 4'b0000 : 4'b0010;
      tick;
      chk("home_valid", cmd_valid, 0);
      chk("home_busy",  busy,      0);
    end
    cw_in   = '0;
    ccw_in  = '0;
    home_in = '0;
    tick;
    exp_q.push_back(mk(1, 1, 1, 0));
    cw_in = 4'b0010;
    tick;
    cw_in = '0;
    wait_idle(20);
`endif

    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
